// File: rtl/multdiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit producing HI/LO over WIDTH+1 cycles.
// Optional build macro MULTDIV_FAST_ZERO_EN: zero operands bypass the iteration.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] orig_a_q, orig_a_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             a_neg, b_neg, skip;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod, prod_neg;

`ifdef MULTDIV_FAST_ZERO_EN
    assign skip = op[1] ? (b == '0) : ((a == '0) || (b == '0));
`else
    assign skip = 1'b0;
`endif

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_abs = a_neg ? ('0 - a) : a;
    assign b_abs = b_neg ? ('0 - b) : b;

    // Multiply: {rem,quo} is the product register, multiplier consumed from quo LSB.
    assign mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, mcand_q} : '0);

    // Divide: quo holds the dividend shifting out MSB-first while quotient bits shift in.
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_diff  = div_shift[WIDTH-1:0] - mcand_q;

    assign prod     = {rem_q, quo_q};
    assign prod_neg = '0 - prod;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        orig_a_d  = orig_a_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    mcand_d   = b_abs;
                    quo_d     = skip ? '0 : a_abs;
                    rem_d     = '0;
                    orig_a_d  = a;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = skip ? SIGN : CALC;
                end
            end
            CALC: begin
                if (op_q[1]) begin
                    rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], div_ge};
                end else begin
                    rem_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = SIGN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SIGN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (mcand_q == '0) begin
                        lo_d  = '1;
                        hi_d  = orig_a_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = neg_res_q ? ('0 - quo_q) : quo_q;
                        hi_d = neg_rem_q ? ('0 - rem_q) : rem_q;
                    end
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            orig_a_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            orig_a_q  <= orig_a_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: vector table plus ignored-start, back-to-back and reset-abort sequences.
module tb_multdiv_unit;

    localparam int unsigned W = 32;
`ifdef MULTDIV_FAST_ZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    multdiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs[12];
    int tests = 0;
    int fails = 0;
    logic [W-1:0] prev_hi = '0, prev_lo = '0;
    bit hold_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        bit z;
        z = o[1] ? (y == '0) : ((x == '0) || (y == '0));
        return (FAST && z) ? 1 : 33;
    endfunction

    // Called at a negedge; returns 1 time unit after the accepting edge.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        check("dbz_cleared", div_by_zero, 0);
    endtask

    task automatic wait_done(output int lat);
        bit seen;
        seen = 0;
        hold_bad = 0;
        lat = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(posedge clk);
            lat = c;
            @(negedge clk);
            if (done) seen = 1;
            else if (hi !== prev_hi || lo !== prev_lo) hold_bad = 1;
        end
        if (!seen) lat = -1;
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic ed);
        int lat;
        start_op(o, x, y);
        wait_done(lat);
        check({nm, "_latency"}, lat, exp_lat(o, x, y));
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
        check({nm, "_dbz"}, div_by_zero, ed);
        check({nm, "_busy_at_done"}, busy, 0);
        check({nm, "_hold"}, hold_bad, 0);
        prev_hi = eh;
        prev_lo = el;
    endtask

    initial begin
        int lat;
        bit seen, done_bad;

        vecs[0]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{2'd1, 32'd0,        32'h00001234, 32'h00000000, 32'h00000000, 1'b0};
        vecs[9]  = '{2'd0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{2'd3, 32'h12345678, 32'h00000100, 32'h00000078, 32'h00123456, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_dbz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dbz);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), done, 0);
        end

        // Start pulse during CALC must be ignored, then back-to-back start in the done cycle.
        start_op(2'd1, 32'd3, 32'd4);
        seen = 0;
        hold_bad = 0;
        lat = -1;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat = c;
            end else begin
                if (hi !== prev_hi || lo !== prev_lo) hold_bad = 1;
                start = (c == 4);
                op = 2'd3; a = 32'd9; b = 32'd3;
            end
        end
        start = 1'b0;
        check("ignore_latency", lat, 33);
        check("ignore_hi", hi, 0);
        check("ignore_lo", lo, 12);
        check("ignore_hold", hold_bad, 0);
        prev_hi = '0;
        prev_lo = 32'd12;
        run_op("b2b", 2'd1, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        // Reset in the middle of an operation aborts it with no visible result.
        @(negedge clk);
        start_op(2'd0, 32'h1234, 32'h10);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        done_bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) done_bad = 1;
        end
        check("abort_no_done", done_bad, 0);
        prev_hi = '0;
        prev_lo = '0;
        run_op("after_abort", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, beside the ALU. It is fed from the same rs/rt operand buses that drive the ALU a/b inputs.
- Replaces the ALU's single-cycle MULT/DIV paths for MIPS MULT, MULTU, DIV and DIVU.
- Produces the architectural HI/LO pair, which MFHI/MFLO consume in writeback.
- Start/busy/done handshake lets the controller stall the pipeline while a 32-step operation runs.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the unit is idle.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo carry a new result.
- hi  output  WIDTH  MULT: upper product; DIV: remainder.
- lo  output  WIDTH  MULT: lower product; DIV: quotient.
- div_by_zero  output  1  set with done for DIV/DIVU with b==0; held until the next accepted start.

Behaviour:
- Reset (synchronous, active-high; clock and reset fixed as clk/reset): state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0.
- Reset mid-operation aborts the operation, returns to IDLE and zeroes all outputs. No partial result is ever visible.
- States: IDLE, CALC, SIGN.
- IDLE:
  - start=1 at edge E0 latches op, a and b, and clears div_by_zero.
  - Signed ops (MULT, DIV) take absolute values of the operands and record the result and remainder signs.
  - Transition to CALC; busy=1 from E0.
- CALC: one shift-add (MULT/MULTU) or restoring shift-subtract (DIV/DIVU) step per cycle for WIDTH cycles (edges E1..E32). Counter wraps WIDTH-1 to 0 on exit to SIGN.
- SIGN, at edge E33:
  - Apply sign correction: two's-complement the 2*WIDTH product if the operand signs differed.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend. Truncation is toward zero.
  - Write hi/lo, set done=1 for exactly one cycle, set busy=0, return to IDLE.
- Latency: done is visible 33 cycles after the start edge (WIDTH+1). The cycle that shows done also shows busy=0, and a new start is accepted in that cycle.
- hi/lo hold the previous result throughout CALC. They change only at SIGN or reset.
- start while busy=1 is ignored: no queuing, no effect on the current operation. op values are ignored when start=0.
- Divide by zero keeps the full latency. Result: lo = all ones, hi = a (original, unsigned view), div_by_zero=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div_by_zero=0.
- Multiply never overflows: the full 2*WIDTH result goes to {hi,lo}.
- Unsigned ops skip all sign handling.

Optional Feature:
- Macro MULTDIV_FAST_ZERO_EN.
- Defined: if, at the start edge, a multiply operand is zero or a divide divisor is zero, skip CALC and go straight to SIGN. done then appears 1 cycle after the start edge, with the same result values as the full path (product 0; divide-by-zero values as above).
- Undefined: every operation takes the fixed WIDTH+1 latency.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> done at start+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy low the same cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; hi/lo hold the prior result during all 32 CALC cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> done at start+33 (start+1 with MULTDIV_FAST_ZERO_EN), lo=0xFFFFFFFF, hi=5, div_by_zero=1. Next accepted start clears div_by_zero.
- Sequence:
  - start MULTU 3*4.
  - Pulse start with DIVU 9/3 at start+5 -> ignored; result hi=0, lo=12.
  - Back-to-back start in the done cycle is accepted -> second done at +33 later.
- Start MULT 0x1234*0x10; assert reset at start+10 for one cycle -> busy=0, done never pulses, hi=lo=0. A following MULT 2*3 yields lo=6 with correct latency.
